branch_offset_encoder: RTL

- Inverse of the fetch/execute branch target path: converts a known branch site PC and a desired target address into the signed 24-bit word offset (imm24), then assembles a complete B/BL instruction word.
- Used by the instruction-patch/boot loader path and the self-check verification harness. Enables round-trip checking against the target generator: target = PC + sext(imm24)<<2 + 4.
- 2-stage valid/ready pipeline with backpressure, alignment and range checks, and a saturating error counter.

---
 rtl/branch_offset_encoder.sv | 98 +++++++++
 1 files changed

// File: rtl/branch_offset_encoder.sv
// Converts a branch site PC and target address into a B/BL instruction word.
// Two-stage valid/ready pipeline with alignment/range checks and a saturating error counter.
module branch_offset_encoder #(
    parameter logic [31:0] PC_OFFSET     = 32'd4,
    parameter int          CHECK_RANGE   = 1,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [31:0]              pcIn,
    input  logic [31:0]              targetIn,
    input  logic [3:0]               condIn,
    input  logic                     linkIn,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              instrOut,
    output logic [23:0]              imm24Out,
    output logic                     misalignedOut,
    output logic                     rangeErrOut,
    output logic [ERR_CNT_WIDTH-1:0] errCount
);

    localparam logic [ERR_CNT_WIDTH-1:0] ErrMax = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ErrOne = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic        s1Valid;
    logic [31:0] s1Diff;
    logic [3:0]  s1Cond;
    logic        s1Link;

    logic        s2Load;
    logic        encMisaligned;
    logic        encRangeErr;
    logic [23:0] encImm;
    logic        outFire;

    // inReady depends combinationally on outReady; there is no skid buffer.
    assign s2Load  = !outValid || outReady;
    assign inReady = !s1Valid || s2Load;
    assign outFire = outValid && outReady;

    always_comb begin
        encMisaligned = (s1Diff[1:0] != 2'b00);
        encRangeErr   = (CHECK_RANGE != 0) && (s1Diff[31:26] != {6{s1Diff[25]}});
        encImm        = s1Diff[25:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Diff  <= 32'h0;
            s1Cond  <= 4'h0;
            s1Link  <= 1'b0;
        end else if (inReady) begin
            s1Valid <= inValid;
            if (inValid) begin
                s1Diff <= targetIn - pcIn - PC_OFFSET;
                s1Cond <= condIn;
                s1Link <= linkIn;
            end
        end
    end

    // Errored results carry zeroed instruction/offset so a loader can never patch in garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid      <= 1'b0;
            instrOut      <= 32'h0;
            imm24Out      <= 24'h0;
            misalignedOut <= 1'b0;
            rangeErrOut   <= 1'b0;
        end else if (s2Load) begin
            outValid <= s1Valid;
            if (s1Valid) begin
                misalignedOut <= encMisaligned;
                rangeErrOut   <= encRangeErr;
                if (encMisaligned || encRangeErr) begin
                    instrOut <= 32'h0;
                    imm24Out <= 24'h0;
                end else begin
                    instrOut <= {s1Cond, 3'b101, s1Link, encImm};
                    imm24Out <= encImm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errCount <= '0;
        end else if (outFire && (misalignedOut || rangeErrOut) && (errCount != ErrMax)) begin
            errCount <= errCount + ErrOne;
        end
    end

endmodule
